// File: rtl/axi_pkg.sv
// Shared AXI definitions: burst encodings, response codes, size/len types.
// Used by the read responder and by the cache read initiators.
package axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2,
    BURST_RSVD  = 2'd3
  } axi_burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef logic [2:0] axi_size_t;
  typedef logic [7:0] axi_len_t;

  // A burst is unserviceable as a whole when its type is reserved or when a
  // WRAP burst has a length that does not describe a power-of-two container.
  function automatic logic burst_illegal(input axi_burst_e burst, input axi_len_t len);
    logic wrap_len_ok;
    wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    return (burst == BURST_RSVD) || ((burst == BURST_WRAP) && !wrap_len_ok);
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational AXI next-beat address generator (FIXED / INCR / WRAP).
// Reserved burst type leaves the address unchanged.
module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 64
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  axi_len_t              len,
  input  axi_size_t             size,
  input  axi_burst_e            burst,
  output logic [ADDR_WIDTH-1:0] next_addr
);

  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] container;
  logic [ADDR_WIDTH-1:0] wrap_mask;
  logic [ADDR_WIDTH-1:0] incr_addr;

  // Step, wrap container and the selected next address for the current beat.
  always_comb begin
    step      = ADDR_WIDTH'(1) << size;
    container = ADDR_WIDTH'({1'b0, len} + 9'd1) << size;
    wrap_mask = container - ADDR_WIDTH'(1);
    incr_addr = addr + step;
    next_addr = addr;
    case (burst)
      BURST_INCR: next_addr = incr_addr;
      BURST_WRAP: next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
      default:    next_addr = addr;
    endcase
  end

endmodule

// File: rtl/axi_rd_responder.sv
// AXI4 read responder backed by an internal word-addressed SRAM with a
// side preload write port. One transaction at a time, programmable first-beat
// latency. Optional macro AXI_RD_RESP_STALL_EN inserts LFSR-driven one-cycle
// rvalid bubbles between beats to exercise master backpressure handling.
//
// state  | meaning
// S_IDLE | arready high, waiting for an address
// S_LAT  | counting down first-beat latency
// S_DATA | presenting beats until rlast is accepted
module axi_rd_responder
  import axi_pkg::*;
#(
  parameter int                    ID_WIDTH      = 13,
  parameter int                    ADDR_WIDTH    = 64,
  parameter int                    DATA_WIDTH    = 64,
  parameter int                    MEM_WORDS_LOG = 11,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = '0,
  parameter int                    LATENCY       = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ID_WIDTH-1:0]      s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]    s_axi_araddr,
  input  logic [7:0]               s_axi_arlen,
  input  logic [2:0]               s_axi_arsize,
  input  logic [1:0]               s_axi_arburst,
  input  logic                     s_axi_arvalid,
  output logic                     s_axi_arready,
  output logic [ID_WIDTH-1:0]      s_axi_rid,
  output logic [DATA_WIDTH-1:0]    s_axi_rdata,
  output logic [1:0]               s_axi_rresp,
  output logic                     s_axi_rlast,
  output logic                     s_axi_rvalid,
  input  logic                     s_axi_rready,
  input  logic                     pre_we,
  input  logic [MEM_WORDS_LOG-1:0] pre_waddr,
  input  logic [DATA_WIDTH-1:0]    pre_wdata
);

  localparam int         MEM_WORDS = 1 << MEM_WORDS_LOG;
  localparam logic [7:0] LAT_LOAD  = 8'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_LAT, S_DATA} state_e;

  state_e state, state_nxt;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  logic [ID_WIDTH-1:0]   id_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  axi_len_t              len_q;
  axi_len_t              beat_q;
  axi_size_t             size_q;
  axi_burst_e            burst_q;
  logic                  bad_q;
  logic [7:0]            lat_q;

  logic                  rvalid_q;
  logic                  rlast_q;
  logic [1:0]            rresp_q;
  logic [ID_WIDTH-1:0]   rid_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic                  ar_fire;
  logic                  first_beat;
  logic                  next_beat;
  logic                  last_done;
  logic                  stall;

  logic [ADDR_WIDTH-1:0] next_addr;
  logic [ADDR_WIDTH-1:0] beat_addr;
  logic [ADDR_WIDTH-1:0] beat_off;
  logic                  beat_in_range;
  logic                  beat_ok;
  logic [MEM_WORDS_LOG-1:0] beat_idx;

  axi_burst_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_gen (
    .addr      (addr_q),
    .len       (len_q),
    .size      (size_q),
    .burst     (burst_q),
    .next_addr (next_addr)
  );

`ifdef AXI_RD_RESP_STALL_EN
  logic [15:0] lfsr_q;

  // Free-running Fibonacci LFSR (taps 16,14,13,11) choosing bubble cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  assign stall = lfsr_q[0];
`else
  assign stall = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and the per-cycle control strobes for the datapath.
  always_comb begin
    state_nxt  = state;
    ar_fire    = 1'b0;
    first_beat = 1'b0;
    next_beat  = 1'b0;
    last_done  = 1'b0;
    case (state)
      S_IDLE: begin
        if (s_axi_arvalid) begin
          ar_fire   = 1'b1;
          state_nxt = S_LAT;
        end
      end
      S_LAT: begin
        if (lat_q == 8'd0) begin
          first_beat = 1'b1;
          state_nxt  = S_DATA;
        end
      end
      S_DATA: begin
        if (rvalid_q && s_axi_rready) begin
          if (rlast_q) begin
            last_done = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            next_beat = 1'b1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Address of the beat being loaded into the output registers this cycle,
  // and whether it maps onto the SRAM.
  always_comb begin
    beat_addr     = first_beat ? addr_q : next_addr;
    beat_off      = beat_addr - BASE_ADDR;
    beat_in_range = (beat_addr >= BASE_ADDR) &&
                    ((beat_off >> (MEM_WORDS_LOG + 3)) == '0);
    beat_idx      = beat_off[MEM_WORDS_LOG+2:3];
    beat_ok       = beat_in_range && !bad_q;
  end

  // Preload port; a same-edge read sees the old word.
  always_ff @(posedge clk) begin
    if (pre_we) begin
      mem[pre_waddr] <= pre_wdata;
    end
  end

  // Burst context, latency counter and the registered R-channel outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      id_q     <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      beat_q   <= '0;
      size_q   <= '0;
      burst_q  <= BURST_FIXED;
      bad_q    <= 1'b0;
      lat_q    <= '0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rid_q    <= '0;
      rdata_q  <= '0;
    end else begin
      if (ar_fire) begin
        id_q    <= s_axi_arid;
        addr_q  <= s_axi_araddr;
        len_q   <= s_axi_arlen;
        size_q  <= s_axi_arsize;
        burst_q <= axi_burst_e'(s_axi_arburst);
        bad_q   <= burst_illegal(axi_burst_e'(s_axi_arburst), s_axi_arlen);
        beat_q  <= '0;
        lat_q   <= LAT_LOAD;
      end else if (state == S_LAT && lat_q != 8'd0) begin
        lat_q <= lat_q - 8'd1;
      end

      if (first_beat || next_beat) begin
        rdata_q <= beat_ok ? mem[beat_idx] : '0;
        rresp_q <= beat_ok ? RESP_OKAY : RESP_SLVERR;
      end

      if (first_beat) begin
        rvalid_q <= 1'b1;
        rid_q    <= id_q;
        rlast_q  <= (len_q == 8'd0);
      end else if (next_beat) begin
        addr_q   <= next_addr;
        beat_q   <= beat_q + 8'd1;
        rlast_q  <= ((beat_q + 8'd1) == len_q);
        rvalid_q <= !stall;
      end else if (last_done) begin
        rvalid_q <= 1'b0;
        rlast_q  <= 1'b0;
      end else if (state == S_DATA && !rvalid_q) begin
        // A withheld beat is released after exactly one bubble cycle.
        rvalid_q <= 1'b1;
      end
    end
  end

  assign s_axi_arready = (state == S_IDLE);
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rlast   = rlast_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rid     = rid_q;
  assign s_axi_rdata   = rdata_q;

endmodule

// File: doc/axi_rd_responder.md
Name: axi_rd_responder

Overview:
AXI4 read-channel slave (responder) backed by an internal word-addressed SRAM. It serves single-beat and burst reads from AXI read masters such as the instruction cache refill path. It is the bench-side and on-chip scratchpad counterpart to the cache read initiators. Processes one transaction at a time, supports FIXED/INCR/WRAP bursts, and has a programmable first-beat latency. A side write port preloads memory contents.

Parameters:
ID_WIDTH, 13, width of arid/rid
ADDR_WIDTH, 64, width of araddr (byte address)
DATA_WIDTH, 64, data beat width; fixed at 64, 8 bytes per word
MEM_WORDS_LOG, 11, log2 of SRAM depth in 64-bit words (2048 words = 16 KiB)
BASE_ADDR, 64'h0, byte address mapped to SRAM word 0
LATENCY, 2, cycles from AR handshake to first rvalid (minimum 1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous active-low reset (0 = reset asserted)
s_axi_arid  in  ID_WIDTH  transaction ID
s_axi_araddr  in  ADDR_WIDTH  byte start address
s_axi_arlen  in  8  beats minus 1
s_axi_arsize  in  3  log2 bytes per beat, 0..3
s_axi_arburst  in  2  0=FIXED, 1=INCR, 2=WRAP, 3=reserved
s_axi_arvalid  in  1  address valid
s_axi_arready  out  1  address accepted
s_axi_rid  out  ID_WIDTH  echoed arid
s_axi_rdata  out  DATA_WIDTH  full 64-bit word containing the beat address
s_axi_rresp  out  2  0=OKAY, 2=SLVERR
s_axi_rlast  out  1  final beat
s_axi_rvalid  out  1  data valid
s_axi_rready  in  1  master accepts data
pre_we  in  1  preload write enable
pre_waddr  in  MEM_WORDS_LOG  preload word index
pre_wdata  in  DATA_WIDTH  preload data

Behaviour:
- Reset, asynchronous, active-low: state=IDLE; arready=1; rvalid=0; rlast=0; rresp=0; rid=0; rdata=0. SRAM contents are not cleared.
- States:
  - IDLE: arready=1. On arvalid&&arready, latch id, addr, len, size, burst. Load the beat counter with 0 and the latency counter with LATENCY-1. Go to LAT. arready drops the next cycle.
  - LAT: count down. At 0, go to DATA and drive beat 0 with rvalid=1.
  - DATA: hold rid, rdata, rresp, rlast stable while rvalid&&!rready.
    - On rready, advance the address.
    - If rlast is set, go to IDLE (arready=1 the next cycle). Otherwise present the next beat the following cycle; sustained throughput is 1 beat/cycle.
- Address advance, with step = 1<<size:
  - FIXED: address unchanged.
  - INCR: addr + step.
  - WRAP: container = (len+1)<<size. Next address = (addr & ~(container-1)) | ((addr+step) & (container-1)).
- Word index = (addr - BASE_ADDR) >> 3, truncated to MEM_WORDS_LOG bits. rdata always returns the full aligned 64-bit word; the master selects the lanes.
- rresp:
  - SLVERR (rdata=0) for a beat whose address lies outside [BASE_ADDR, BASE_ADDR + 8<<MEM_WORDS_LOG).
  - SLVERR for every beat when arburst=3.
  - SLVERR for every beat when WRAP has len not in {1,3,7,15}.
  - Otherwise OKAY. Length is always honoured: exactly len+1 beats, rlast on the last.
- INCR crossing the top of SRAM: beats past the end return SLVERR; no wrap to word 0.
- Preload port: writes the SRAM on the clock edge, in any state. A same-cycle read of the same word returns the old data (read-before-write).
- Reset asserted mid-burst: the burst is abandoned immediately and rvalid drops asynchronously. No further beats are sent for that burst.

Optional Feature:
- AXI_RD_RESP_STALL_EN:
  - Defined: a 16-bit LFSR (taps 16,14,13,11; seed 16'hACE1 at reset) advances every cycle. In DATA, while no beat is pending, the next beat's rvalid is withheld for one cycle whenever LFSR[0]=1. This exercises master rready/rvalid backpressure tolerance.
  - Undefined: no bubbles; a beat is presented every cycle once DATA is entered.

Decomposition:
- Shared package axi_pkg: burst enum (FIXED/INCR/WRAP), resp constants (OKAY=2'b00, SLVERR=2'b10), and size/len typedefs. The cache initiators use the same package.
- One sub-module, axi_burst_addr_gen: combinational next-address and wrap-container logic, reusable by future read and write initiators.

Test Plan:
- Preload words 0..7 = 64'h1000+i. Send WRAP, addr 0x28, len 7, size 3, id 5, rready=1. Required: 8 beats with data 0x1005,0x1006,0x1007,0x1000..0x1004; rid=5; rlast on beat 8 only; first rvalid LATENCY cycles after AR.
- INCR, addr 0x0, len 3, size 3, with rready low for 3 cycles on beat 1. Required: beat 1 data held stable; total 4 beats 0x1000..0x1003; arready stays 0 until after rlast.
- FIXED, addr 0x10, len 2. Required: 3 beats, each 0x1002, rresp=OKAY.
- INCR starting at the last SRAM word (index 2047), len 1. Required: beat 0 OKAY with the stored data; beat 1 SLVERR with rdata=0; rlast on beat 1.
- WRAP with len 2, and separately arburst=3. Required: every beat SLVERR, beat count len+1.
- Assert reset (drive 0) during beat 2 of an 8-beat INCR. Required: rvalid=0 immediately, arready=1 after release, and a new AR then completes normally.
